reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with rename tags. Sits directly downstream of the reorder buffer's commit port and upstream of decode/issue.
- Holds 32 x 32-bit registers. Each register has a reorder tag naming the in-flight ROB entry that will produce its next value.
- Decode reads operands combinationally and receives either a value or a pending tag. Decode also renames rd on dispatch.
- The ROB writes committed values. A commit clears the tag only if the tag still matches. Misbranch flushes all tags.

Parameters:
- REG_NUM, 32, number of architectural registers (index width 5)
- DATA_W, 32, register data width
- ROB_TAG_W, 4, reorder tag width; tag 0 means "no pending producer"

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rdy  in  1  global ready; when low, all state holds
- in_decode_rs1  in  5  source register 1 index
- in_decode_rs2  in  5  source register 2 index
- out_decode_value1  out  32  rs1 value (valid when out_decode_reorder1 == 0)
- out_decode_reorder1  out  ROB_TAG_W  rs1 pending tag, 0 if value ready
- out_decode_value2  out  32  rs2 value
- out_decode_reorder2  out  ROB_TAG_W  rs2 pending tag
- in_decode_rd  in  5  destination register being renamed
- in_decode_rd_reorder  in  ROB_TAG_W  new ROB tag for rd; 0 = no rename this cycle
- in_rob_index  in  5  committed destination register; 0 = no write
- in_rob_value  in  32  committed value
- in_rob_reorder  in  ROB_TAG_W  ROB tag of the committing entry
- in_misbranch  in  1  flush from ROB

Behaviour:
- Storage: value[0..31] (32 bits each) and tag[0..31] (ROB_TAG_W each). Register 0 always reads value 0, tag 0. Writes and renames to index 0 are ignored.
- Reset (rst == 0 at posedge clk): all values and all tags become 0. Reset wins over rdy and every other input.
- Read path is purely combinational, with zero latency. For port k with index r:
  - If r == 0: output value 0, tag 0.
  - Else if in_rob_index == r, r != 0, in_rob_reorder != 0 and tag[r] == in_rob_reorder: bypass. Output value = in_rob_value, tag = 0.
  - Else: output value = value[r], tag = tag[r].
  - Reads never see a same-cycle rename. An instruction reading its own rd (e.g. addi x1,x1,1) sees the pre-rename state.
- Commit (posedge, rdy == 1, in_rob_index != 0):
  - value[in_rob_index] <= in_rob_value, unconditionally.
  - tag[in_rob_index] <= 0 only if tag[in_rob_index] == in_rob_reorder. Otherwise the tag is kept, because a younger producer owns the register.
- Rename (posedge, rdy == 1, in_misbranch == 0, in_decode_rd_reorder != 0, in_decode_rd != 0): tag[in_decode_rd] <= in_decode_rd_reorder.
- Same-register commit and rename in one cycle: the rename wins on the tag, the value is still written, and the tag ends equal to the new rename tag.
- Misbranch (posedge, rdy == 1, in_misbranch == 1):
  - All tags are cleared to 0.
  - The same-cycle rename is discarded.
  - The same-cycle commit value is still written. A JALR commit arrives in the same cycle as the misbranch.
- rdy == 0: no state changes. Combinational outputs still track the inputs.
- No internal FSM beyond per-register tag state. Each register moves free (tag 0) -> pending (tag != 0) on rename, and back to free on a matching commit or on misbranch. A pending register retags on a younger rename.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> value1=0, reorder1=0, value2=0, reorder2=0. Write rob index 0 with value 0xDEAD -> x0 still reads 0.
- Rename x3 to tag 2. Next cycle read x3 -> reorder1=2. Commit index 3, value 0x1234, tag 2 -> same-cycle read gives value 0x1234, tag 0. Next cycle: stored value 0x1234, tag 0.
- Rename x4 to tag 1, then rename x4 to tag 5. Commit x4 tag 1, value 7 -> value[4]=7, tag stays 5. Read x4 returns reorder 5 and no bypass.
- Same cycle: commit x6 (tag 3, value 9) and rename x6 to tag 4 -> tag[6]=4, value[6]=9. Same-cycle read of x6 bypasses to value 9, tag 0.
- Rename x1..x8 to tags 1..8. Assert in_misbranch together with commit x2 (tag 2, value 0x80) and rename x9 to tag 9 -> all tags 0, value[2]=0x80, x9 not renamed.
- Hold rdy=0 while driving rename x7 to tag 3 and commit x7 (value 1) -> no state change. Raise rdy -> the update takes effect on that edge.

Source files
------------

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : Architectural register file with per-register rename tags.
//            Sits between the reorder buffer commit port and decode/issue.
//            Each register carries a reorder tag naming the in-flight ROB
//            entry that will produce its next value; tag 0 means the stored
//            value is current.
//
// Ports    :
//   clk                   system clock
//   rst                   synchronous reset, active low (wins over all)
//   rdy                   global ready; low freezes all state
//   in_decode_rs1/rs2     source operand indices (combinational read)
//   out_decode_value1/2   operand values (meaningful when reorder is 0)
//   out_decode_reorder1/2 pending producer tag, 0 when the value is ready
//   in_decode_rd          destination register being renamed
//   in_decode_rd_reorder  new ROB tag for rd, 0 = no rename this cycle
//   in_rob_index          committed destination register, 0 = no write
//   in_rob_value          committed value
//   in_rob_reorder        ROB tag of the committing entry
//   in_misbranch          flush: clears every rename tag
//
// Revision : 1.0  initial release
// ============================================================================
module reg_file #(
    parameter  int REG_NUM   = 32,
    parameter  int DATA_W    = 32,
    parameter  int ROB_TAG_W = 4,
    localparam int IDX_W     = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,

    input  logic [IDX_W-1:0]     in_decode_rs1,
    input  logic [IDX_W-1:0]     in_decode_rs2,
    output logic [DATA_W-1:0]    out_decode_value1,
    output logic [ROB_TAG_W-1:0] out_decode_reorder1,
    output logic [DATA_W-1:0]    out_decode_value2,
    output logic [ROB_TAG_W-1:0] out_decode_reorder2,

    input  logic [IDX_W-1:0]     in_decode_rd,
    input  logic [ROB_TAG_W-1:0] in_decode_rd_reorder,

    input  logic [IDX_W-1:0]     in_rob_index,
    input  logic [DATA_W-1:0]    in_rob_value,
    input  logic [ROB_TAG_W-1:0] in_rob_reorder,

    input  logic                 in_misbranch
);

    localparam logic [IDX_W-1:0]     C_IDX_ZERO = '0;
    localparam logic [ROB_TAG_W-1:0] C_TAG_NONE = '0;

    // ------------------------------------------------------------------------
    // Storage. Entry 0 is reset to zero and never written, so it is a
    // hard-wired zero; the read path also forces it for clarity.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]    value_q [REG_NUM];
    logic [DATA_W-1:0]    value_d [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_q   [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_d   [REG_NUM];

    logic w_commit_en;
    logic w_rename_en;
    logic w_flush_en;

    assign w_commit_en = rdy && (in_rob_index != C_IDX_ZERO);
    assign w_flush_en  = rdy && in_misbranch;
    assign w_rename_en = rdy && !in_misbranch
                      && (in_decode_rd_reorder != C_TAG_NONE)
                      && (in_decode_rd != C_IDX_ZERO);

    // ------------------------------------------------------------------------
    // Next-state. Order of the updates encodes priority on the tag field:
    // matching commit clears, a same-cycle rename overrides the clear, and a
    // flush overrides everything. The committed value is written regardless
    // of tag match or flush (a JALR commits in the same cycle it flushes).
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            value_d[i] = value_q[i];
            tag_d[i]   = tag_q[i];
        end

        if (w_commit_en) begin
            value_d[in_rob_index] = in_rob_value;
            // A mismatch means a younger rename now owns the register.
            if (tag_q[in_rob_index] == in_rob_reorder) begin
                tag_d[in_rob_index] = C_TAG_NONE;
            end
        end

        if (w_rename_en) begin
            tag_d[in_decode_rd] = in_decode_rd_reorder;
        end

        if (w_flush_en) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = C_TAG_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path. A commit landing this cycle on the register, from the very
    // producer its tag waits on, is forwarded so decode need not stall a
    // cycle. Same-cycle renames are deliberately invisible to reads so an
    // instruction reading its own rd sees the pre-rename state. The bypass
    // is not gated by rdy: outputs follow inputs even while frozen.
    // ------------------------------------------------------------------------
    function automatic logic [DATA_W+ROB_TAG_W-1:0] read_port(
        input logic [IDX_W-1:0] idx
    );
        logic [DATA_W-1:0]    val;
        logic [ROB_TAG_W-1:0] tag;
        val = value_q[idx];
        tag = tag_q[idx];
        if (idx == C_IDX_ZERO) begin
            val = '0;
            tag = C_TAG_NONE;
        end else if ((in_rob_index == idx)
                  && (in_rob_reorder != C_TAG_NONE)
                  && (tag_q[idx] == in_rob_reorder)) begin
            val = in_rob_value;
            tag = C_TAG_NONE;
        end
        return {val, tag};
    endfunction

    always_comb begin
        {out_decode_value1, out_decode_reorder1} = read_port(in_decode_rs1);
    end

    always_comb begin
        {out_decode_value2, out_decode_reorder2} = read_port(in_decode_rs2);
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Directed, self-checking bench for reg_file. One task per
//            scenario; each drives stimulus and checks outputs inline.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [4:0]  rs1, rs2, rd, rob_index;
    logic [3:0]  rd_reorder, rob_reorder;
    logic [31:0] rob_value;
    logic        misbranch;
    logic [31:0] value1, value2;
    logic [3:0]  reorder1, reorder2;

    int errors;
    int checks;

    reg_file #(
        .REG_NUM   (32),
        .DATA_W    (32),
        .ROB_TAG_W (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .in_decode_rs1        (rs1),
        .in_decode_rs2        (rs2),
        .out_decode_value1    (value1),
        .out_decode_reorder1  (reorder1),
        .out_decode_value2    (value2),
        .out_decode_reorder2  (reorder2),
        .in_decode_rd         (rd),
        .in_decode_rd_reorder (rd_reorder),
        .in_rob_index         (rob_index),
        .in_rob_value         (rob_value),
        .in_rob_reorder       (rob_reorder),
        .in_misbranch         (misbranch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst         = 1'b1;
        rdy         = 1'b1;
        rd          = 5'd0;
        rd_reorder  = 4'd0;
        rob_index   = 5'd0;
        rob_value   = 32'd0;
        rob_reorder = 4'd0;
        misbranch   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b0;
        rd = 5'd5; rd_reorder = 4'd3;
        rob_index = 5'd5; rob_value = 32'hABCD; rob_reorder = 4'd3;
        tick();
        tick();
        idle();
        rs1 = 5'd5; rs2 = 5'd0; #1;
        checks++; if (value1 !== 32'd0) begin errors++; $display("FAIL reset_value1: got %h want %h", value1, 32'd0); end
        checks++; if (reorder1 !== 4'd0) begin errors++; $display("FAIL reset_reorder1: got %0d want %0d", reorder1, 0); end
        checks++; if (value2 !== 32'd0) begin errors++; $display("FAIL reset_value2: got %h want %h", value2, 32'd0); end
        checks++; if (reorder2 !== 4'd0) begin errors++; $display("FAIL reset_reorder2: got %0d want %0d", reorder2, 0); end
        // Writes and renames to x0 are ignored.
        rob_index = 5'd0; rob_value = 32'hDEAD; rob_reorder = 4'd1;
        rd = 5'd0; rd_reorder = 4'd6;
        rs1 = 5'd0; #1;
        checks++; if (value1 !== 32'd0) begin errors++; $display("FAIL x0_bypass_value: got %h want %h", value1, 32'd0); end
        tick();
        idle();
        checks++; if (value1 !== 32'd0 || reorder1 !== 4'd0) begin errors++; $display("FAIL x0_stored: got %h/%0d want 0/0", value1, reorder1); end
    endtask

    task automatic test_rename_commit();
        rd = 5'd3; rd_reorder = 4'd2;
        tick();
        idle();
        rs1 = 5'd3; rs2 = 5'd3; #1;
        checks++; if (reorder1 !== 4'd2) begin errors++; $display("FAIL rename_tag: got %0d want %0d", reorder1, 2); end
        rob_index = 5'd3; rob_value = 32'h1234; rob_reorder = 4'd2; #1;
        checks++; if (value1 !== 32'h1234 || reorder1 !== 4'd0) begin errors++; $display("FAIL bypass_port1: got %h/%0d want 00001234/0", value1, reorder1); end
        checks++; if (value2 !== 32'h1234 || reorder2 !== 4'd0) begin errors++; $display("FAIL bypass_port2: got %h/%0d want 00001234/0", value2, reorder2); end
        tick();
        idle();
        checks++; if (value1 !== 32'h1234 || reorder1 !== 4'd0) begin errors++; $display("FAIL commit_stored: got %h/%0d want 00001234/0", value1, reorder1); end
    endtask

    task automatic test_stale_commit();
        rd = 5'd4; rd_reorder = 4'd1;
        tick();
        rd_reorder = 4'd5;
        tick();
        idle();
        rs1 = 5'd4;
        rob_index = 5'd4; rob_value = 32'd7; rob_reorder = 4'd1; #1;
        checks++; if (value1 !== 32'd0 || reorder1 !== 4'd5) begin errors++; $display("FAIL stale_no_bypass: got %h/%0d want 00000000/5", value1, reorder1); end
        tick();
        idle();
        checks++; if (value1 !== 32'd7 || reorder1 !== 4'd5) begin errors++; $display("FAIL stale_stored: got %h/%0d want 00000007/5", value1, reorder1); end
    endtask

    task automatic test_back_to_back();
        rd = 5'd6; rd_reorder = 4'd3;
        tick();
        idle();
        rs1 = 5'd6;
        rob_index = 5'd6; rob_value = 32'd9; rob_reorder = 4'd3;
        rd = 5'd6; rd_reorder = 4'd4; #1;
        checks++; if (value1 !== 32'd9 || reorder1 !== 4'd0) begin errors++; $display("FAIL b2b_bypass: got %h/%0d want 00000009/0", value1, reorder1); end
        tick();
        idle();
        checks++; if (value1 !== 32'd9 || reorder1 !== 4'd4) begin errors++; $display("FAIL b2b_stored: got %h/%0d want 00000009/4", value1, reorder1); end
    endtask

    task automatic test_misbranch();
        for (int i = 1; i <= 8; i++) begin
            rd = 5'(i); rd_reorder = 4'(i);
            tick();
        end
        idle();
        rs1 = 5'd8; #1;
        checks++; if (reorder1 !== 4'd8) begin errors++; $display("FAIL pre_flush_tag: got %0d want %0d", reorder1, 8); end
        misbranch = 1'b1;
        rob_index = 5'd2; rob_value = 32'h80; rob_reorder = 4'd2;
        rd = 5'd9; rd_reorder = 4'd9;
        tick();
        idle();
        rs1 = 5'd2; rs2 = 5'd9; #1;
        checks++; if (value1 !== 32'h80 || reorder1 !== 4'd0) begin errors++; $display("FAIL flush_commit: got %h/%0d want 00000080/0", value1, reorder1); end
        checks++; if (value2 !== 32'd0 || reorder2 !== 4'd0) begin errors++; $display("FAIL flush_rename_dropped: got %h/%0d want 00000000/0", value2, reorder2); end
        for (int i = 1; i <= 8; i++) begin
            rs1 = 5'(i); #1;
            checks++; if (reorder1 !== 4'd0) begin errors++; $display("FAIL flush_tag_x%0d: got %0d want 0", i, reorder1); end
        end
    endtask

    task automatic test_rdy_hold();
        rdy = 1'b0;
        rd = 5'd7; rd_reorder = 4'd3;
        rob_index = 5'd7; rob_value = 32'd1; rob_reorder = 4'd3;
        rs1 = 5'd7; #1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (value1 !== 32'd0 || reorder1 !== 4'd0) begin errors++; $display("FAIL rdy_hold: got %h/%0d want 00000000/0", value1, reorder1); end
        rdy = 1'b1;
        tick();
        idle();
        checks++; if (value1 !== 32'd1 || reorder1 !== 4'd3) begin errors++; $display("FAIL rdy_release: got %h/%0d want 00000001/3", value1, reorder1); end
        // A frozen flush must not clear tags either.
        rdy = 1'b0; misbranch = 1'b1;
        tick();
        idle();
        checks++; if (reorder1 !== 4'd3) begin errors++; $display("FAIL rdy_flush_hold: got %0d want %0d", reorder1, 3); end
    endtask

    task automatic test_top_register();
        rd = 5'd31; rd_reorder = 4'd15;
        tick();
        idle();
        rs2 = 5'd31; #1;
        checks++; if (reorder2 !== 4'd15) begin errors++; $display("FAIL x31_tag: got %0d want %0d", reorder2, 15); end
        rob_index = 5'd31; rob_value = 32'hFFFF_FFFF; rob_reorder = 4'd15;
        tick();
        idle();
        checks++; if (value2 !== 32'hFFFF_FFFF || reorder2 !== 4'd0) begin errors++; $display("FAIL x31_commit: got %h/%0d want ffffffff/0", value2, reorder2); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        idle();
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_back_to_back();
        test_misbranch();
        test_rdy_hold();
        test_top_register();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
